bin2gray_counter: RTL

- Parameterised binary up/down counter whose registered state is also presented in reflected-binary Gray code.
- This block is the encoding side of the 4-bit Gray-to-binary converter. It is the pointer source for clock-domain-crossing logic: the Gray output is safe to synchronise into another domain, where the converter decodes it back to binary.
- Supports synchronous load, hold, count direction, and a registered wrap pulse.

---
 rtl/bin2gray_counter_pkg.sv | 12 +
 rtl/bin2gray_comb.sv | 25 ++
 rtl/bin2gray_counter.sv | 68 ++++++
 3 files changed

// File: rtl/bin2gray_counter_pkg.sv
// Shared constants and the binary-to-Gray helper used by the counter and its bench.
package bin2gray_counter_pkg;

  localparam int WIDTH_DEF = 4;
  // Widest code the helper handles; callers zero-extend into it. Counter widths must stay below it.
  localparam int MAX_WIDTH = 64;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] value);
    return value ^ (value >> 1);
  endfunction

endpackage

// File: rtl/bin2gray_comb.sv
// Purely combinational WIDTH-bit binary-to-reflected-Gray converter.
module bin2gray_comb
  import bin2gray_counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  logic [MAX_WIDTH-1:0] bin_wide;
  logic [MAX_WIDTH-1:0] gray_wide;
  logic                 unused_hi;

  always_comb begin
    bin_wide            = '0;
    bin_wide[WIDTH-1:0] = bin;
  end

  assign gray_wide = bin2gray(bin_wide);
  assign gray      = gray_wide[WIDTH-1:0];
  // Upper bits are always zero because the input is zero-extended.
  assign unused_hi = ^gray_wide[MAX_WIDTH-1:WIDTH];

endmodule

// File: rtl/bin2gray_counter.sv
// Up/down binary counter with a registered Gray-code copy and a registered wrap pulse.
module bin2gray_counter
  import bin2gray_counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             wrap_q;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;
  logic             wrap_next;

  localparam logic [WIDTH-1:0] STEP = {{(WIDTH-1){1'b0}}, 1'b1};

  // Priority: load, then count, otherwise hold. Wrap flags the modular carry/borrow only.
  always_comb begin
    bin_next  = bin_q;
    wrap_next = 1'b0;
    if (load) begin
      bin_next = load_bin;
    end else if (en) begin
      if (up) begin
        bin_next  = bin_q + STEP;
        wrap_next = &bin_q;
      end else begin
        bin_next  = bin_q - STEP;
        wrap_next = ~|bin_q;
      end
    end
  end

  // Gray is encoded from the next binary value so both registers update on the same edge.
  bin2gray_comb #(
    .WIDTH (WIDTH)
  ) u_bin2gray_comb (
    .bin  (bin_next),
    .gray (gray_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_next;
      gray_q <= gray_next;
      wrap_q <= wrap_next;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign wrap = wrap_q;

endmodule
